// File: rtl/packet_pkg.sv
// Shared definitions for the router packet buffer: in-slot field offsets, SIZE field width,
// CRC-8 polynomial, receiver FSM states and a byte-wide CRC-8 update helper.
package packet_pkg;

  localparam int unsigned OFF_SRC_ID = 0;
  localparam int unsigned OFF_DST_ID = 1;
  localparam int unsigned OFF_SIZE   = 2;
  localparam int unsigned OFF_DATA   = 3;

  localparam int unsigned SIZE_BITS = 3;

  localparam logic [7:0] CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    StIdle,
    StSrc,
    StDst,
    StSize,
    StData,
    StCrc,
    StGap,
    StDrop
  } rx_state_e;

  // CRC-8, MSB first, one whole byte per call.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/packet_receiver_if.sv
// Byte stream plus packet-buffer write port seen by packet_receiver.
// master drives the stream and buffer status; slave is the receiver.
interface packet_receiver_if #(
  parameter int unsigned UWIDTH    = 8,
  parameter int unsigned PTR_IN_SZ = 4
);

  logic [UWIDTH-1:0]    packet_in;
  logic                 packet_valid_in;
  logic                 wfull;
  logic                 wen;
  logic [PTR_IN_SZ-1:0] waddr_in;
  logic [UWIDTH-1:0]    wdata;
  logic                 winc;

  modport master (
    output packet_in,
    output packet_valid_in,
    output wfull,
    input  wen,
    input  waddr_in,
    input  wdata,
    input  winc
  );

  modport slave (
    input  packet_in,
    input  packet_valid_in,
    input  wfull,
    output wen,
    output waddr_in,
    output wdata,
    output winc
  );

endinterface

// File: rtl/crc8_accum.sv
// Running CRC-8 register. i_clear restarts from 0x00; when i_clear and i_en coincide the
// byte is folded into a fresh CRC so the first byte of a packet is never lost.
module crc8_accum
  import packet_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;
  logic [7:0] w_base;

  assign w_base = i_clear ? 8'h00 : r_crc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_crc <= 8'h00;
    end else if (i_en) begin
      r_crc <= crc8_update(w_base, i_data);
    end else if (i_clear) begin
      r_crc <= 8'h00;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/packet_receiver.sv
// Router ingress: writes SRC/DST/SIZE/DATA/CRC bytes into the current buffer slot and commits
// it with winc. Optional CRC verification is enabled by PACKET_RECEIVER_CRC_CHECK_EN.
module packet_receiver
  import packet_pkg::*;
#(
  parameter int unsigned UWIDTH    = 8,
  parameter int unsigned PTR_IN_SZ = 4
) (
  input  logic              clk,
  input  logic              rst,
  packet_receiver_if.slave  bus,
  output logic              crc_err,
  output logic [7:0]        drop_cnt
);

  rx_state_e              r_state, w_state_d;
  logic [PTR_IN_SZ-1:0]   r_addr, w_addr_d;
  logic [SIZE_BITS-1:0]   r_remain, w_remain_d;
  logic                   r_wen, w_wen;
  logic [PTR_IN_SZ-1:0]   r_waddr, w_waddr;
  logic [UWIDTH-1:0]      r_wdata;
  logic                   r_pend;
  logic                   r_winc, w_winc_d;
  logic [7:0]             r_drop_cnt;
  logic                   w_drop_inc;
  logic                   w_drop_any;
  logic                   w_crc_done;

  always_comb begin
    w_state_d  = r_state;
    w_addr_d   = r_addr;
    w_remain_d = r_remain;
    w_wen      = 1'b0;
    w_waddr    = r_waddr;
    w_drop_inc = 1'b0;
    w_crc_done = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.packet_valid_in) begin
          if (bus.wfull) begin
            w_state_d  = StDrop;
            w_drop_inc = 1'b1;
          end else begin
            w_wen     = 1'b1;
            w_waddr   = PTR_IN_SZ'(OFF_SRC_ID);
            w_state_d = StDst;
          end
        end
      end
      StDst: begin
        if (bus.packet_valid_in) begin
          w_wen     = 1'b1;
          w_waddr   = PTR_IN_SZ'(OFF_DST_ID);
          w_state_d = StSize;
        end else begin
          w_state_d  = StIdle;
          w_drop_inc = 1'b1;
        end
      end
      StSize: begin
        if (bus.packet_valid_in) begin
          w_wen      = 1'b1;
          w_waddr    = PTR_IN_SZ'(OFF_SIZE);
          w_remain_d = bus.packet_in[SIZE_BITS-1:0];
          w_addr_d   = PTR_IN_SZ'(OFF_DATA);
          if (bus.packet_in[SIZE_BITS-1:0] == '0) begin
            w_state_d  = StDrop;
            w_drop_inc = 1'b1;
          end else begin
            w_state_d = StData;
          end
        end else begin
          w_state_d  = StIdle;
          w_drop_inc = 1'b1;
        end
      end
      StData: begin
        if (bus.packet_valid_in) begin
          w_wen      = 1'b1;
          w_waddr    = r_addr;
          w_addr_d   = r_addr + PTR_IN_SZ'(1);
          w_remain_d = r_remain - SIZE_BITS'(1);
          if (r_remain == SIZE_BITS'(1)) begin
            w_state_d = StCrc;
          end
        end else begin
          w_state_d  = StIdle;
          w_drop_inc = 1'b1;
        end
      end
      StCrc: begin
        if (bus.packet_valid_in) begin
          w_wen      = 1'b1;
          w_waddr    = r_addr;
          w_crc_done = 1'b1;
          w_state_d  = StGap;
        end else begin
          w_state_d  = StIdle;
          w_drop_inc = 1'b1;
        end
      end
      StGap, StDrop: begin
        if (!bus.packet_valid_in) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

`ifdef PACKET_RECEIVER_CRC_CHECK_EN
  logic [7:0] w_crc;
  logic       r_pend_ok;
  logic       r_crc_err;

  // CRC covers every written byte except the trailing CRC byte itself.
  crc8_accum u_crc (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == StIdle),
    .i_en    (w_wen & ~w_crc_done),
    .i_data  (8'(bus.packet_in)),
    .o_crc   (w_crc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_ok <= 1'b0;
      r_crc_err <= 1'b0;
    end else begin
      r_pend_ok <= w_crc_done && (w_crc == 8'(bus.packet_in));
      r_crc_err <= r_pend & ~r_pend_ok;
    end
  end

  assign w_winc_d   = r_pend & r_pend_ok;
  assign w_drop_any = w_drop_inc | (r_pend & ~r_pend_ok);
  assign crc_err    = r_crc_err;
`else
  assign w_winc_d   = r_pend;
  assign w_drop_any = w_drop_inc;
  assign crc_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_remain   <= '0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_pend     <= 1'b0;
      r_winc     <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else begin
      r_state  <= w_state_d;
      r_addr   <= w_addr_d;
      r_remain <= w_remain_d;
      r_wen    <= w_wen;
      if (w_wen) begin
        r_waddr <= w_waddr;
        r_wdata <= bus.packet_in;
      end
      // r_pend marks the cycle after the CRC write; winc follows one cycle later.
      r_pend <= w_crc_done;
      r_winc <= w_winc_d;
      if (w_drop_any && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign bus.wen      = r_wen;
  assign bus.waddr_in = r_waddr;
  assign bus.wdata    = r_wdata;
  assign bus.winc     = r_winc;
  assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_packet_receiver.sv
// Scoreboard bench for packet_receiver: a packet-level reference model queues expected writes
// and commit/error pulses; a monitor pops and compares whenever the DUT presents one.
module tb_packet_receiver;

  localparam int unsigned UW = 8;
  localparam int unsigned PW = 4;

`ifdef PACKET_RECEIVER_CRC_CHECK_EN
  localparam bit CrcChk = 1'b1;
`else
  localparam bit CrcChk = 1'b0;
`endif

  typedef enum int {EvWrite, EvWinc, EvErr} ev_e;
  typedef struct {
    ev_e         kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       crc_err;
  logic [7:0] drop_cnt;

  ev_t        exp_q[$];
  logic [7:0] pkt[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         model_drops = 0;
  int         cyc = 0;
  int         last_wen_cyc = -10;

  packet_receiver_if #(.UWIDTH(UW), .PTR_IN_SZ(PW)) bus ();

  packet_receiver #(.UWIDTH(UW), .PTR_IN_SZ(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .crc_err  (crc_err),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Bit-serial CRC-8 (poly x^8+x^2+x+1, init 0) over the first len bytes.
  function automatic logic [7:0] ref_crc(input logic [7:0] m[$], input int len);
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    for (int i = 0; i < len; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ m[i][b];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    end
    return r;
  endfunction

  task automatic push_ev(input ev_e k, input int a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = 32'(a);
    e.data = {24'h0, d};
    exp_q.push_back(e);
  endtask

  task automatic count_drop();
    if (model_drops < 255) model_drops++;
  endtask

  // Packet-level expectation: what lands in the slot and whether it commits.
  task automatic model(input logic [7:0] p[$], input bit full);
    int len;
    int n;
    int lim;
    len = p.size();
    if (full) begin
      count_drop();
    end else if (len < 3) begin
      for (int i = 0; i < len; i++) push_ev(EvWrite, i, p[i]);
      count_drop();
    end else begin
      n   = int'(p[2] & 8'h07);
      lim = (n == 0) ? 3 : 4 + n;
      for (int i = 0; i < len && i < lim; i++) push_ev(EvWrite, i, p[i]);
      if (n == 0 || len < lim) begin
        count_drop();
      end else if (!CrcChk || ref_crc(p, lim - 1) == p[lim-1]) begin
        push_ev(EvWinc, 0, 8'h00);
      end else begin
        push_ev(EvErr, 0, 8'h00);
        count_drop();
      end
    end
  endtask

  task automatic send(input logic [7:0] p[$], input bit full);
    model(p, full);
    for (int i = 0; i < p.size(); i++) begin
      @(negedge clk);
      bus.packet_in       = p[i];
      bus.packet_valid_in = 1'b1;
      bus.wfull           = (i == 0) ? full : 1'($urandom);
    end
    @(negedge clk);
    bus.packet_valid_in = 1'b0;
    bus.packet_in       = 8'($urandom);
    bus.wfull           = 1'($urandom);
    repeat (3) @(negedge clk);
    check("drop_cnt", {24'h0, drop_cnt}, 32'(model_drops));
  endtask

  // Builds a packet into pkt with the given SIZE byte; good selects a correct CRC.
  task automatic build(input logic [7:0] szf, input bit good);
    int n;
    pkt.delete();
    pkt.push_back(8'($urandom));
    pkt.push_back(8'($urandom));
    pkt.push_back(szf);
    n = int'(szf & 8'h07);
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
    pkt.push_back(ref_crc(pkt, pkt.size()) ^ (good ? 8'h00 : 8'(1 + $urandom_range(0, 254))));
  endtask

  task automatic pop_check(input ev_e k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    bit  ok;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_output: got kind=%0d addr=%0h data=%0h, none expected", k, a, d);
    end else begin
      e  = exp_q.pop_front();
      ok = (e.kind == k);
      if (k == EvWrite) ok = ok && (e.addr == a) && (e.data == d);
      else              ok = ok && (cyc == last_wen_cyc + 1);
      if (!ok) begin
        n_err++;
        $display("FAIL output_event: got kind=%0d addr=%0h data=%0h cyc=%0d, expected kind=%0d addr=%0h data=%0h (last wen cyc %0d)",
                 k, a, d, cyc, e.kind, e.addr, e.data, last_wen_cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      if (bus.winc === 1'b1) pop_check(EvWinc, 32'h0, 32'h0);
      if (crc_err === 1'b1)  pop_check(EvErr, 32'h0, 32'h0);
      if (bus.wen === 1'b1) begin
        pop_check(EvWrite, {28'h0, bus.waddr_in}, {24'h0, bus.wdata});
        last_wen_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] good_pkt[$];
    int         len;
    bus.packet_in       = 8'h00;
    bus.packet_valid_in = 1'b0;
    bus.wfull           = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_wen", {31'h0, bus.wen}, 32'h0);
    check("reset_waddr", {28'h0, bus.waddr_in}, 32'h0);
    check("reset_wdata", {24'h0, bus.wdata}, 32'h0);
    check("reset_winc", {31'h0, bus.winc}, 32'h0);
    check("reset_crc_err", {31'h0, crc_err}, 32'h0);
    check("reset_drop_cnt", {24'h0, drop_cnt}, 32'h0);
    #2 rst = 1'b1;

    // Reference packet, then the same with a corrupted CRC.
    good_pkt = {8'h05, 8'h0A, 8'h02, 8'h11, 8'h22};
    good_pkt.push_back(ref_crc(good_pkt, 5));
    send(good_pkt, 1'b0);
    pkt = good_pkt;
    pkt[5] = pkt[5] ^ 8'h01;
    send(pkt, 1'b0);

    // Buffer full at start, then accepted normally.
    pkt = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send(pkt, 1'b1);
    send(good_pkt, 1'b0);

    // SIZE=0 drops after the header; SIZE=7 fills the slot up to addr 10.
    pkt = {8'h10, 8'h20, 8'h00, 8'h33, 8'h44};
    send(pkt, 1'b0);
    build(8'h07, 1'b1);
    send(pkt, 1'b0);
    build(8'hF8, 1'b1);
    send(pkt, 1'b0);

    // Valid falls after the 2nd data byte of a SIZE=3 packet.
    build(8'h03, 1'b1);
    while (pkt.size() > 5) void'(pkt.pop_back());
    send(pkt, 1'b0);

    // Extra bytes past CRC are never written.
    build(8'h02, 1'b1);
    pkt.push_back(8'hEE);
    pkt.push_back(8'hDD);
    send(pkt, 1'b0);

    for (int k = 0; k < 60; k++) begin
      build(8'($urandom), ($urandom_range(0, 3) != 0));
      case ($urandom_range(0, 7))
        0: begin
          len = $urandom_range(1, pkt.size() - 1);
          while (pkt.size() > len) void'(pkt.pop_back());
        end
        1: for (int j = 0; j < $urandom_range(1, 3); j++) pkt.push_back(8'($urandom));
        default: ;
      endcase
      send(pkt, ($urandom_range(0, 9) == 0));
    end

    // Reset in the middle of a packet.
    build(8'h03, 1'b1);
    for (int i = 0; i < 3; i++) push_ev(EvWrite, i, pkt[i]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.packet_in       = pkt[i];
      bus.packet_valid_in = 1'b1;
      bus.wfull           = 1'b0;
    end
    @(negedge clk);
    #2 rst = 1'b0;
    bus.packet_valid_in = 1'b0;
    #1;
    check("midrst_wen", {31'h0, bus.wen}, 32'h0);
    check("midrst_waddr", {28'h0, bus.waddr_in}, 32'h0);
    check("midrst_wdata", {24'h0, bus.wdata}, 32'h0);
    check("midrst_winc", {31'h0, bus.winc}, 32'h0);
    check("midrst_drop_cnt", {24'h0, drop_cnt}, 32'h0);
    model_drops = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    send(good_pkt, 1'b0);

    // Saturation of the drop counter.
    for (int k = 0; k < 300; k++) begin
      pkt = {8'hAA};
      send(pkt, 1'b1);
    end
    check("drop_cnt_saturated", {24'h0, drop_cnt}, 32'd255);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/packet_receiver.md
# packet_receiver

Ingress stage of the custom router. Accepts a byte-serial packet stream (SRC_ID, DST_ID, SIZE, DATA…, CRC), writes each packet into the current slot of the packet buffer at fixed in-slot offsets, and commits the slot with a one-cycle `winc` pulse once the packet completes intact. It feeds the buffer that `packet_sender` drains: the receiver is the write side, the sender the read side.

## Interface
Parameters:
- `UWIDTH`, 8, byte/word width of stream and buffer.
- `PTR_IN_SZ`, 4, in-slot address width; 2^PTR_IN_SZ ≥ 11.

Ports:
- `clk`  in  1  clock; all registers update on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `packet_in`  in  UWIDTH  stream byte.
- `packet_valid_in`  in  1  byte on `packet_in` valid this cycle; high contiguously for a whole packet.
- `wfull`  in  1  buffer has no free slot.
- `wen`  out  1  buffer write strobe.
- `waddr_in`  out  PTR_IN_SZ  in-slot write address.
- `wdata`  out  UWIDTH  write data.
- `winc`  out  1  commit current slot; one-cycle pulse.
- `crc_err`  out  1  one-cycle pulse on CRC mismatch.
- `drop_cnt`  out  8  dropped-packet count, saturating at 255.

## Operation
- In-slot layout: SRC_ID→0, DST_ID→1, SIZE→2, DATA→3…3+N-1, CRC→3+N; N = SIZE[2:0], legal 1..7.
- States: IDLE, SRC, DST, SIZE, DATA, CRC, GAP, DROP.
- IDLE: `packet_valid_in`=1 and `wfull`=0 → byte written to addr 0 as SRC, go DST; `packet_valid_in`=1 and `wfull`=1 → DROP.
- DST, SIZE: write byte at addr 1 / 2. SIZE latches N=`packet_in[2:0]`; N=0 → DROP.
- DATA: write at 3+i, decrement remaining count; after N-th byte go CRC.
- CRC: write byte at 3+N; then commit (see Configuration); go GAP.
- GAP: ignore bytes until `packet_valid_in`=0, then IDLE. Extra bytes past CRC are never written.
- DROP: no writes; wait for `packet_valid_in`=0, then IDLE. `drop_cnt` increments once per DROP entry.
- `packet_valid_in` falling before CRC byte (any of DST..CRC) → abort: no `winc`, `drop_cnt`+1, IDLE. Partial slot contents are don't-care (overwritten by next packet).
- CRC-8, poly 0x07, init 0x00, MSB-first, over SRC, DST, SIZE, DATA bytes.
- Reset mid-packet: all state discarded, no `winc`; next packet starts fresh from IDLE.
- Reset values: `wen`=0, `waddr_in`=0, `wdata`=0, `winc`=0, `crc_err`=0, `drop_cnt`=0, state IDLE.

## Timing
- Byte sampled on edge k → `wen`=1, `waddr_in`, `wdata` registered and valid in cycle k..k+1. One write per accepted byte, no bubbles.
- `winc` / `crc_err` pulse exactly one cycle, in the cycle after the CRC byte's `wen` cycle.
- `wfull` sampled only in IDLE at SRC acceptance; later changes ignored for that packet.
- Back-to-back packets need ≥1 cycle with `packet_valid_in`=0 between them.

## Configuration
- `PACKET_RECEIVER_CRC_CHECK_EN` defined: computed CRC compared to received CRC byte. Match → `winc` pulse. Mismatch → no `winc`, `crc_err` pulse, `drop_cnt`+1.
- Undefined: no CRC logic; `winc` pulses for every completed packet; `crc_err` tied 0. CRC byte is still written to the slot.

## Structure
- Shared package `packet_pkg`: field offsets SRC_ID=0, DST_ID=1, SIZE=2, DATA=3; SIZE_BITS=3; CRC_POLY=8'h07; receiver state enum.
- Sub-module `crc8_accum`: sequential CRC register with `clear` and `en` inputs, byte-wide update. Instantiated only under `PACKET_RECEIVER_CRC_CHECK_EN`.

## Test plan
- Packet 05,0A,02,11,22,CRC(good): writes addr0..5 = 05,0A,02,11,22,CRC on consecutive cycles; one `winc` the next cycle; `drop_cnt`=0.
- Same packet with CRC byte XOR 0x01, macro defined: all six writes occur; no `winc`; `crc_err` pulses once; `drop_cnt`=1. Macro undefined: `winc` pulses; `crc_err` stays 0.
- `wfull`=1 at packet start, 7-byte packet: no `wen`, no `winc`; `drop_cnt`=1. Next packet with `wfull`=0 is accepted normally.
- SIZE=0x00 packet: writes at addr 0..2 only, then DROP; no `winc`; `drop_cnt`+1. SIZE=0x07: data at addr 3..9, CRC at addr 10, `winc`.
- `packet_valid_in` falls after 2nd data byte of SIZE=3 packet: no `winc`; `drop_cnt`+1. Assert `rst` mid-packet: all outputs 0 immediately; no `winc`.
- 300 dropped packets: `drop_cnt` saturates at 255.
